// File: rtl/led_pkg.sv
// Shared constants and FSM encoding for the LED state sequencer.
package led_pkg;

    localparam int NUM_ST = 5;   // pattern-state blocks sequenced
    localparam int LED_W  = 18;  // LED bus width
    localparam int IDX_W  = 3;   // width of the state index / cur_st bus

    // Legacy-compatible state encoding: plain vector type plus named constants
    typedef logic [1:0] seq_state_t;
    localparam seq_state_t S_IDLE   = 2'd0;
    localparam seq_state_t S_ACTIVE = 2'd1;
    localparam seq_state_t S_GAP    = 2'd2;

    // LED value driven whenever no pattern block is active
    localparam logic [LED_W-1:0] IDLE_PATTERN = '0;

endpackage

// File: rtl/seq_timeout_timer.sv
// Watchdog counter for one ACTIVE state: cleared outside ACTIVE, counts each
// enabled clk and saturates at TIMEOUT-1, where expire is raised.
module seq_timeout_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic async_rs_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_reg;

    // Count ACTIVE clks; saturation keeps expire asserted if the FSM lingers
    always_ff @(posedge clk or negedge async_rs_n) begin
        if (!async_rs_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LAST_CNT)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expire = (count_reg == LAST_CNT);

endmodule

// File: rtl/led_state_sequencer.sv
// Sequences NUM_ST LED pattern blocks: one-hot begin per state, a one-clk gap
// between states, auto-cycle or hold-one-state mode, and a per-state timeout.
module led_state_sequencer #(
    parameter int NUM_ST  = led_pkg::NUM_ST,
    parameter int LED_W   = led_pkg::LED_W,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    async_rs_n,
    input  logic                    run,
    input  logic                    mode,
    input  logic [2:0]              hold_sel,
    input  logic [NUM_ST-1:0]       st_over,
    input  logic [NUM_ST*LED_W-1:0] st_pat,
    output logic [NUM_ST-1:0]       st_begin,
    output logic                    enabler,
    output logic [LED_W-1:0]        led_out,
    output logic [2:0]              cur_st,
    output logic                    cycle_done,
    output logic                    err_to
);

    import led_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ST - 1);

    seq_state_t       state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [LED_W-1:0] led_out_reg, led_next;
    logic             err_to_reg, err_next;
    logic             cycle_done_reg, done_next;
    logic [IDX_W-1:0] eff_sel;
    logic             over_cur;
    logic             expire;
    logic [LED_W-1:0] pat_arr [NUM_ST];

    // Out-of-range hold selections fall back to state 0
    assign eff_sel  = ({29'd0, hold_sel} < 32'(NUM_ST)) ? hold_sel : '0;
    // Only the active block's done flag matters
    assign over_cur = st_over[idx_reg];

    generate
        for (genvar gi = 0; gi < NUM_ST; gi++) begin : g_state
            assign pat_arr[gi]  = st_pat[gi*LED_W +: LED_W];
            assign st_begin[gi] = (state_reg == S_ACTIVE) && (idx_reg == IDX_W'(gi));
        end
    endgenerate

    seq_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk        (clk),
        .async_rs_n (async_rs_n),
        .clear      (state_reg != S_ACTIVE),
        .enable     (state_reg == S_ACTIVE),
        .expire     (expire)
    );

    // Next-state, next-index and pulse decisions; run=0 overrides everything
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        err_next   = 1'b0;
        done_next  = 1'b0;
        if (!run) begin
            state_next = S_IDLE;
            idx_next   = '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    state_next = S_ACTIVE;
                    idx_next   = mode ? eff_sel : '0;
                end
                S_ACTIVE: begin
                    // Completion wins over a coincident timeout
                    if (over_cur || expire) begin
                        state_next = S_GAP;
                        err_next   = !over_cur;
                        done_next  = !mode && (idx_reg == LAST_IDX);
                    end
                end
                S_GAP: begin
                    state_next = S_ACTIVE;
                    if (mode)
                        idx_next = eff_sel;
                    else if (idx_reg == LAST_IDX)
                        idx_next = '0;
                    else
                        idx_next = idx_reg + 1'b1;
                end
                default: begin
                    state_next = S_IDLE;
                    idx_next   = '0;
                end
            endcase
        end
        // LED register is loaded for the state being entered so it lines up with ACTIVE
        led_next = (state_next == S_ACTIVE) ? pat_arr[idx_next] : LED_W'(IDLE_PATTERN);
    end

    // State, index, LED and pulse registers
    always_ff @(posedge clk or negedge async_rs_n) begin
        if (!async_rs_n) begin
            state_reg      <= S_IDLE;
            idx_reg        <= '0;
            led_out_reg    <= '0;
            err_to_reg     <= 1'b0;
            cycle_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            led_out_reg    <= led_next;
            err_to_reg     <= err_next;
            cycle_done_reg <= done_next;
        end
    end

    assign enabler    = (state_reg != S_IDLE);
    assign cur_st     = (state_reg == S_IDLE) ? 3'd0 : idx_reg;
    assign led_out    = led_out_reg;
    assign err_to     = err_to_reg;
    assign cycle_done = cycle_done_reg;

endmodule

// File: tb/tb_led_state_sequencer.sv
// Directed bench for led_state_sequencer: auto cycle, hold, timeout,
// simultaneous done/timeout, stop/restart and asynchronous reset.
module tb_led_state_sequencer;

    localparam int NUM_ST = 5;
    localparam int LED_W  = 18;

    logic                    clk = 1'b0;
    logic                    async_rs_n;
    logic                    run;
    logic                    mode;
    logic [2:0]              hold_sel;
    logic [NUM_ST-1:0]       st_over;
    logic [NUM_ST*LED_W-1:0] st_pat;
    logic [NUM_ST-1:0]       st_begin;
    logic                    enabler;
    logic [LED_W-1:0]        led_out;
    logic [2:0]              cur_st;
    logic                    cycle_done;
    logic                    err_to;

    logic [LED_W-1:0] pat [NUM_ST];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    led_state_sequencer #(
        .NUM_ST  (NUM_ST),
        .LED_W   (LED_W),
        .TIMEOUT (64)
    ) dut (
        .clk        (clk),
        .async_rs_n (async_rs_n),
        .run        (run),
        .mode       (mode),
        .hold_sel   (hold_sel),
        .st_over    (st_over),
        .st_pat     (st_pat),
        .st_begin   (st_begin),
        .enabler    (enabler),
        .led_out    (led_out),
        .cur_st     (cur_st),
        .cycle_done (cycle_done),
        .err_to     (err_to)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        pat[0] = 18'h00001;
        pat[1] = 18'h00030;
        pat[2] = 18'h00700;
        pat[3] = 18'h0F000;
        pat[4] = 18'h30005;
        st_pat = {pat[4], pat[3], pat[2], pat[1], pat[0]};
        async_rs_n = 1'b0;
        run = 1'b0;
        mode = 1'b0;
        hold_sel = 3'd0;
        st_over = '0;

        // Reset state
        tick(2);
        chk("rst_begin", 32'(st_begin), 32'h0);
        chk("rst_en", 32'(enabler), 32'h0);
        chk("rst_led", 32'(led_out), 32'h0);
        chk("rst_cur", 32'(cur_st), 32'h0);
        chk("rst_done", 32'(cycle_done), 32'h0);
        chk("rst_err", 32'(err_to), 32'h0);
        $display("reset: begin=%b en=%b led=%h", st_begin, enabler, led_out);

        async_rs_n = 1'b1;
        tick(1);
        chk("idle_begin", 32'(st_begin), 32'h0);
        chk("idle_en", 32'(enabler), 32'h0);

        // Auto cycle: each state done 40 clks after its begin
        run = 1'b1;
        tick(1);
        for (int k = 0; k < NUM_ST; k++) begin
            chk("auto_begin", 32'(st_begin), 32'(1 << k));
            chk("auto_cur", 32'(cur_st), 32'(k));
            chk("auto_led", 32'(led_out), 32'(pat[k]));
            chk("auto_en", 32'(enabler), 32'h1);
            // Stray done flags on every other block must be ignored
            st_over = NUM_ST'(~(1 << k));
            tick(1);
            chk("stray_begin", 32'(st_begin), 32'(1 << k));
            st_over = '0;
            tick(38);
            st_over = NUM_ST'(1 << k);
            tick(1);
            st_over = '0;
            chk("gap_begin", 32'(st_begin), 32'h0);
            chk("gap_en", 32'(enabler), 32'h1);
            chk("gap_led", 32'(led_out), 32'h0);
            chk("gap_cur", 32'(cur_st), 32'(k));
            chk("gap_err", 32'(err_to), 32'h0);
            chk("gap_done", 32'(cycle_done), (k == NUM_ST - 1) ? 32'h1 : 32'h0);
            $display("auto state %0d: gap cur=%0d done=%b", k, cur_st, cycle_done);
            tick(1);
        end
        chk("wrap_begin", 32'(st_begin), 32'h1);
        chk("wrap_cur", 32'(cur_st), 32'h0);
        chk("wrap_done", 32'(cycle_done), 32'h0);

        // Timeout: no done flag, GAP 64 clks after ACTIVE entry
        tick(63);
        chk("to_still_active", 32'(st_begin), 32'h1);
        chk("to_no_err_yet", 32'(err_to), 32'h0);
        tick(1);
        chk("to_gap_begin", 32'(st_begin), 32'h0);
        chk("to_err", 32'(err_to), 32'h1);
        chk("to_cur", 32'(cur_st), 32'h0);
        $display("timeout: err_to=%b begin=%b", err_to, st_begin);
        tick(1);
        chk("to_adv_begin", 32'(st_begin), 32'h2);
        chk("to_err_once", 32'(err_to), 32'h0);

        // Done flag on the expiry clk: normal completion, no err_to
        tick(63);
        st_over = 5'b00010;
        tick(1);
        st_over = '0;
        chk("sim_gap_begin", 32'(st_begin), 32'h0);
        chk("sim_err", 32'(err_to), 32'h0);
        $display("simultaneous: err_to=%b cur=%0d", err_to, cur_st);
        tick(1);
        chk("sim_adv_begin", 32'(st_begin), 32'h4);

        // Stop mid-state 2, then restart at state 0
        tick(5);
        chk("stop_pre_led", 32'(led_out), 32'(pat[2]));
        run = 1'b0;
        tick(1);
        chk("stop_begin", 32'(st_begin), 32'h0);
        chk("stop_en", 32'(enabler), 32'h0);
        chk("stop_led", 32'(led_out), 32'h0);
        chk("stop_cur", 32'(cur_st), 32'h0);
        $display("stop: begin=%b en=%b led=%h", st_begin, enabler, led_out);
        run = 1'b1;
        tick(1);
        chk("rerun_begin", 32'(st_begin), 32'h1);
        chk("rerun_led", 32'(led_out), 32'(pat[0]));

        // Hold mode, hold_sel=3; mode change during ACTIVE waits for the GAP
        mode = 1'b1;
        hold_sel = 3'd3;
        st_over = 5'b00001;
        tick(1);
        st_over = '0;
        chk("hold_gap_cur", 32'(cur_st), 32'h0);
        chk("hold_gap_done", 32'(cycle_done), 32'h0);
        tick(1);
        chk("hold3_begin_a", 32'(st_begin), 32'h8);
        chk("hold3_led", 32'(led_out), 32'(pat[3]));
        st_over = 5'b01000;
        tick(1);
        st_over = '0;
        chk("hold3_gap", 32'(st_begin), 32'h0);
        tick(1);
        chk("hold3_begin_b", 32'(st_begin), 32'h8);
        $display("hold sel=3: begin=%b cur=%0d", st_begin, cur_st);
        hold_sel = 3'd7;
        tick(1);
        chk("hold7_deferred", 32'(st_begin), 32'h8);
        st_over = 5'b01000;
        tick(1);
        st_over = '0;
        chk("hold7_gap_cur", 32'(cur_st), 32'h3);
        tick(1);
        chk("hold7_begin", 32'(st_begin), 32'h1);
        $display("hold sel=7: begin=%b cur=%0d", st_begin, cur_st);

        // Asynchronous reset mid-ACTIVE clears outputs before any clk edge
        tick(3);
        #2 async_rs_n = 1'b0;
        #1;
        chk("arst_begin", 32'(st_begin), 32'h0);
        chk("arst_en", 32'(enabler), 32'h0);
        chk("arst_led", 32'(led_out), 32'h0);
        chk("arst_cur", 32'(cur_st), 32'h0);
        chk("arst_err", 32'(err_to), 32'h0);
        $display("async reset: begin=%b en=%b led=%h", st_begin, enabler, led_out);
        tick(1);
        async_rs_n = 1'b1;
        mode = 1'b0;
        hold_sel = 3'd0;
        tick(1);
        chk("arst_restart", 32'(st_begin), 32'h1);
        chk("arst_no_pulse", 32'({cycle_done, err_to}), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_state_sequencer.md
LED_STATE_SEQUENCER -- requirements
Module: led_state_sequencer

Interface
REQ-001 SHALL have parameter NUM_ST, default 5: number of pattern-state blocks sequenced.
REQ-002 SHALL have parameter LED_W, default 18: LED bus width.
REQ-003 SHALL have parameter TIMEOUT, default 64: max clk cycles a state may stay active without its over flag.
REQ-004 SHALL have port clk, input, 1: single clock, all flops on rising edge.
REQ-005 SHALL have port async_rs_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port run, input, 1: level; 1 = sequence runs, 0 = stop and return to idle.
REQ-007 SHALL have port mode, input, 1: 0 = auto-cycle through all states, 1 = repeat hold_sel only.
REQ-008 SHALL have port hold_sel, input, 3: state index repeated when mode=1.
REQ-009 SHALL have port st_over, input, NUM_ST: per-state done flags from the pattern blocks.
REQ-010 SHALL have port st_pat, input, NUM_ST*LED_W: concatenated patterns; state k occupies bits [k*LED_W +: LED_W].
REQ-011 SHALL have port st_begin, output, NUM_ST: one-hot begin to the pattern blocks.
REQ-012 SHALL have port enabler, output, 1: common enable to all pattern blocks.
REQ-013 SHALL have port led_out, output, LED_W: registered selected pattern.
REQ-014 SHALL have port cur_st, output, 3: active state index.
REQ-015 SHALL have port cycle_done, output, 1: one-clk pulse when the last state completes in auto mode.
REQ-016 SHALL have port err_to, output, 1: one-clk pulse when a state times out.

Function
REQ-017 SHALL implement FSM states IDLE, ACTIVE, GAP with a registered index idx in 0..NUM_ST-1.
REQ-018 IDLE, run=1: SHALL go to ACTIVE next clk, with idx=0 in auto mode or idx=eff_sel in hold mode.
REQ-019 eff_sel SHALL equal hold_sel when hold_sel<NUM_ST, else 0.
REQ-020 In ACTIVE, st_begin SHALL be one-hot at bit idx, and enabler SHALL be 1.
REQ-021 In ACTIVE, only st_over[idx] SHALL be evaluated; other st_over bits SHALL be ignored.
REQ-022 ACTIVE with st_over[idx]=1 SHALL go to GAP next clk, and st_begin SHALL become all 0 so the block self-resets.
REQ-023 The timeout counter SHALL clear on entry to ACTIVE and increment each ACTIVE clk.
REQ-024 Counter reaching TIMEOUT-1 with st_over[idx]=0 SHALL go to GAP and pulse err_to.
REQ-025 When st_over[idx] and timeout occur in the same clk, the transition SHALL be treated as normal completion with no err_to.
REQ-026 GAP SHALL last exactly one clk with st_begin=0 and enabler=1, then go to ACTIVE with the next idx.
REQ-027 Next idx in auto mode SHALL be idx+1, wrapping from NUM_ST-1 to 0; cycle_done SHALL pulse in the GAP clk after the wrap decision.
REQ-028 Next idx in hold mode SHALL be eff_sel sampled in the GAP clk.
REQ-029 Changes to mode or hold_sel during ACTIVE SHALL take effect only at the next GAP.
REQ-030 run=0 in any state SHALL go to IDLE next clk, with st_begin=0 and enabler=0; any run=1 afterwards restarts per REQ-018.
REQ-031 led_out SHALL equal the st_pat slice at idx, registered one clk after ACTIVE; in IDLE and GAP it SHALL be 0.
REQ-032 cur_st SHALL equal idx in ACTIVE and GAP, and 0 in IDLE.

Reset
REQ-033 async_rs_n=0 SHALL immediately force IDLE, idx=0, counter=0, st_begin=0, enabler=0, led_out=0, cur_st=0, cycle_done=0, err_to=0.
REQ-034 Reset release SHALL take effect on the first clk edge after async_rs_n returns to 1; reset mid-ACTIVE SHALL leave no pending pulses.

Structure
REQ-035 Shared package led_pkg SHALL hold NUM_ST, LED_W, the FSM state typedef, and the IDLE_PATTERN constant (all zeros).
REQ-036 The timeout counter SHALL be a sub-module seq_timeout_timer (clear, enable, TIMEOUT parameter, expire output); the FSM and mux SHALL stay in the top.

Verification
REQ-037 Auto run: reset, run=1, each st_over[k] raised 40 clks after begin -> st_begin 00001, 00010, … 10000, each separated by one all-zero clk; cycle_done pulses once; idx wraps to 0.
REQ-038 Hold: mode=1, hold_sel=3 -> st_begin repeats 01000 with one-clk gaps; hold_sel=7 -> repeats 00001.
REQ-039 Timeout: st_over never asserted, TIMEOUT=64 -> GAP entered 64 clks after ACTIVE entry, err_to pulses once, idx advances.
REQ-040 Simultaneous: st_over[idx] raised on the expiry clk -> normal advance with err_to=0; stray st_over[j≠idx]=1 -> no effect.
REQ-041 Stop/reset: run dropped mid-state 2 -> next clk st_begin=0, enabler=0, led_out=0; rerun starts at state 0; async_rs_n pulsed mid-ACTIVE -> all outputs 0 before the next clk edge.
